morse_keyer: RTL and testbench



---
 rtl/morse_pkg.sv | 56 +++++
 rtl/morse_unit_tick.sv | 38 +++
 rtl/morse_keyer.sv | 168 ++++++++++++++++
 tb/tb_morse_keyer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : morse_pkg
//  Description : Shared types and constants for the Morse transmit engine:
//                FSM state encoding, symbol values and A-Z letter codes.
//                Letter code bit 0 is the first symbol sent (1 = dash).
//  Revision    : 1.0 - initial release
// ============================================================================
package morse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MARK  = 3'd1,
        ST_SPACE = 3'd2,
        ST_LGAP  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;

    // Letter descriptor: symbol vector plus symbol count
    typedef struct packed {
        logic [4:0] code;
        logic [2:0] len;
    } letter_t;

    localparam letter_t LETTER_A = '{code: 5'b00010, len: 3'd2};  // .-
    localparam letter_t LETTER_B = '{code: 5'b00001, len: 3'd4};  // -...
    localparam letter_t LETTER_C = '{code: 5'b00101, len: 3'd4};  // -.-.
    localparam letter_t LETTER_D = '{code: 5'b00001, len: 3'd3};  // -..
    localparam letter_t LETTER_E = '{code: 5'b00000, len: 3'd1};  // .
    localparam letter_t LETTER_F = '{code: 5'b00100, len: 3'd4};  // ..-.
    localparam letter_t LETTER_G = '{code: 5'b00011, len: 3'd3};  // --.
    localparam letter_t LETTER_H = '{code: 5'b00000, len: 3'd4};  // ....
    localparam letter_t LETTER_I = '{code: 5'b00000, len: 3'd2};  // ..
    localparam letter_t LETTER_J = '{code: 5'b01110, len: 3'd4};  // .---
    localparam letter_t LETTER_K = '{code: 5'b00101, len: 3'd3};  // -.-
    localparam letter_t LETTER_L = '{code: 5'b00010, len: 3'd4};  // .-..
    localparam letter_t LETTER_M = '{code: 5'b00011, len: 3'd2};  // --
    localparam letter_t LETTER_N = '{code: 5'b00001, len: 3'd2};  // -.
    localparam letter_t LETTER_O = '{code: 5'b00111, len: 3'd3};  // ---
    localparam letter_t LETTER_P = '{code: 5'b00110, len: 3'd4};  // .--.
    localparam letter_t LETTER_Q = '{code: 5'b01011, len: 3'd4};  // --.-
    localparam letter_t LETTER_R = '{code: 5'b00010, len: 3'd3};  // .-.
    localparam letter_t LETTER_S = '{code: 5'b00000, len: 3'd3};  // ...
    localparam letter_t LETTER_T = '{code: 5'b00001, len: 3'd1};  // -
    localparam letter_t LETTER_U = '{code: 5'b00100, len: 3'd3};  // ..-
    localparam letter_t LETTER_V = '{code: 5'b01000, len: 3'd4};  // ...-
    localparam letter_t LETTER_W = '{code: 5'b00110, len: 3'd3};  // .--
    localparam letter_t LETTER_X = '{code: 5'b01001, len: 3'd4};  // -..-
    localparam letter_t LETTER_Y = '{code: 5'b01101, len: 3'd4};  // -.--
    localparam letter_t LETTER_Z = '{code: 5'b00011, len: 3'd4};  // --..

endpackage : morse_pkg
`default_nettype wire

// File: rtl/morse_unit_tick.sv
`default_nettype none
// ============================================================================
//  Module      : morse_unit_tick
//  Description : Unit-time tick generator. Counts enabled clock cycles and
//                pulses tick on the last cycle of each Morse unit. clear
//                restarts the unit so a new state always gets a full unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module morse_unit_tick #(
    parameter int TICKS_PER_UNIT = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = $clog2(TICKS_PER_UNIT);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(TICKS_PER_UNIT - 1);

    logic [CNT_W-1:0] r_cnt;

    assign tick = enable && (r_cnt == c_last);

    // Cycle counter: clear wins, otherwise count while enabled and wrap at unit end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= tick ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule : morse_unit_tick
`default_nettype wire

// File: rtl/morse_keyer.sv
`default_nettype none
// ============================================================================
//  Module      : morse_keyer
//  Description : Morse transmit engine. Accepts one letter per valid/ready
//                handshake and plays it on key_o with dot 1u, dash DASH_UNITS,
//                intra-letter gap 1u and letter gap LETTER_GAP_UNITS.
//                All outputs are registered alongside the state.
//  Revision    : 1.0 - initial release
// ============================================================================
module morse_keyer
    import morse_pkg::*;
#(
    parameter int MAX_LEN          = 5,
    parameter int TICKS_PER_UNIT   = 25_000_000,
    parameter int DASH_UNITS       = 3,
    parameter int LETTER_GAP_UNITS = 3
) (
    input  logic                         CLOCK50_i,
    input  logic                         rst_ni,
    input  logic [MAX_LEN-1:0]           code_i,
    input  logic [$clog2(MAX_LEN+1)-1:0] len_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic                         abort_i,
    output logic                         key_o,
    output logic                         dotLed_o,
    output logic                         dashLed_o,
    output logic                         doneLed_o,
    output logic                         busy_o
);

    localparam int LEN_W    = $clog2(MAX_LEN + 1);
    localparam int UNIT_MAX = (DASH_UNITS > LETTER_GAP_UNITS) ? DASH_UNITS : LETTER_GAP_UNITS;
    localparam int UNIT_W   = $clog2(UNIT_MAX + 1);
    localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_LEN);
    // Output bundle order: {key, dot, dash, done, ready, busy}
    localparam logic [5:0] c_outs_idle = 6'b000010;

    state_t             r_state;
    logic [MAX_LEN-1:0] r_code;    // remaining symbols, current one at bit 0
    logic [LEN_W-1:0]   r_left;    // symbols still to send, including current
    logic               r_dash;    // current mark is a dash
    logic [UNIT_W-1:0]  r_units;   // units elapsed in the current state
    logic [5:0]         r_outs;

    logic [LEN_W-1:0]   w_len_clip;
    logic [UNIT_W-1:0]  w_units_need;
    logic               w_unit_last;
    logic               w_tick;
    logic               w_advance;
    logic               w_clear;

    function automatic logic [5:0] decode_outs(input state_t s, input logic sym);
        case (s)
            ST_MARK:           return {1'b1, sym == SYM_DOT, sym == SYM_DASH, 3'b001};
            ST_SPACE, ST_LGAP: return 6'b000001;
            ST_DONE:           return 6'b000110;
            default:           return c_outs_idle;
        endcase
    endfunction

    assign {key_o, dotLed_o, dashLed_o, doneLed_o, ready_o, busy_o} = r_outs;

    assign w_len_clip = (len_i > c_max_len) ? c_max_len : len_i;

    // Length of the current state in units
    always_comb begin
        w_units_need = UNIT_W'(1);
        case (r_state)
            ST_MARK: w_units_need = r_dash ? UNIT_W'(DASH_UNITS) : UNIT_W'(1);
            ST_LGAP: w_units_need = UNIT_W'(LETTER_GAP_UNITS);
            default: w_units_need = UNIT_W'(1);
        endcase
    end

    assign w_unit_last = (r_units == w_units_need - UNIT_W'(1));
    assign w_advance   = w_tick && w_unit_last;
    // Restart unit timing on accept, abort and every state change
    assign w_clear     = abort_i || (valid_i && r_outs[1]) || w_advance;

    morse_unit_tick #(
        .TICKS_PER_UNIT(TICKS_PER_UNIT)
    ) u_unit_tick (
        .clk   (CLOCK50_i),
        .rst_n (rst_ni),
        .clear (w_clear),
        .enable(r_outs[0]),
        .tick  (w_tick)
    );

    // Letter FSM with registered outputs; abort overrides every transition
    always_ff @(posedge CLOCK50_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_code  <= '0;
            r_left  <= '0;
            r_dash  <= 1'b0;
            r_units <= '0;
            r_outs  <= c_outs_idle;
        end else if (abort_i) begin
            r_state <= ST_IDLE;
            r_code  <= '0;
            r_left  <= '0;
            r_dash  <= 1'b0;
            r_units <= '0;
            r_outs  <= c_outs_idle;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (valid_i) begin
                        r_code  <= code_i;
                        r_left  <= w_len_clip;
                        r_dash  <= code_i[0];
                        r_units <= '0;
                        if (w_len_clip == '0) begin
                            r_state <= ST_LGAP;
                            r_outs  <= decode_outs(ST_LGAP, 1'b0);
                        end else begin
                            r_state <= ST_MARK;
                            r_outs  <= decode_outs(ST_MARK, code_i[0]);
                        end
                    end
                end
                ST_MARK: begin
                    if (w_advance) begin
                        r_units <= '0;
                        r_code  <= r_code >> 1;
                        r_left  <= r_left - LEN_W'(1);
                        if (r_left == LEN_W'(1)) begin
                            r_state <= ST_LGAP;
                            r_outs  <= decode_outs(ST_LGAP, 1'b0);
                        end else begin
                            r_state <= ST_SPACE;
                            r_outs  <= decode_outs(ST_SPACE, 1'b0);
                        end
                    end else if (w_tick) begin
                        r_units <= r_units + UNIT_W'(1);
                    end
                end
                ST_SPACE: begin
                    if (w_advance) begin
                        r_units <= '0;
                        r_dash  <= r_code[0];
                        r_state <= ST_MARK;
                        r_outs  <= decode_outs(ST_MARK, r_code[0]);
                    end else if (w_tick) begin
                        r_units <= r_units + UNIT_W'(1);
                    end
                end
                ST_LGAP: begin
                    if (w_advance) begin
                        r_units <= '0;
                        r_state <= ST_DONE;
                        r_outs  <= decode_outs(ST_DONE, 1'b0);
                    end else if (w_tick) begin
                        r_units <= r_units + UNIT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_outs  <= c_outs_idle;
                end
            endcase
        end
    end

endmodule : morse_keyer
`default_nettype wire

// File: tb/tb_morse_keyer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_morse_keyer
//  Description : Directed self-checking bench for morse_keyer with
//                TICKS_PER_UNIT=4, MAX_LEN=5. Cycle n is the cycle following
//                rising edge n-1, where edge 0 is the accept edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_morse_keyer;
    import morse_pkg::*;

    logic       clk = 1'b0;
    logic       r_rst_n;
    logic [4:0] r_code;
    logic [2:0] r_len;
    logic       r_valid;
    logic       r_abort;
    logic       w_ready, w_key, w_dot, w_dash, w_done, w_busy;
    logic [5:0] w_outs;

    int n_checks = 0;
    int n_errors = 0;
    int first_done;

    // {key, dot, dash, done, ready, busy}
    localparam logic [5:0] c_idle = 6'b000010;

    assign w_outs = {w_key, w_dot, w_dash, w_done, w_ready, w_busy};

    always #5 clk = ~clk;

    morse_keyer #(
        .MAX_LEN         (5),
        .TICKS_PER_UNIT  (4),
        .DASH_UNITS      (3),
        .LETTER_GAP_UNITS(3)
    ) dut (
        .CLOCK50_i(clk),
        .rst_ni   (r_rst_n),
        .code_i   (r_code),
        .len_i    (r_len),
        .valid_i  (r_valid),
        .ready_o  (w_ready),
        .abort_i  (r_abort),
        .key_o    (w_key),
        .dotLed_o (w_dot),
        .dashLed_o(w_dash),
        .doneLed_o(w_done),
        .busy_o   (w_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs at cycle c of a letter: marks of 4/12 cycles, 4-cycle
    // spaces between symbols, 12-cycle letter gap, then done held.
    function automatic logic [5:0] exp_outs(input logic [4:0] code, input logic [2:0] len, input int c);
        int eff;
        int t;
        int m;
        eff = (len > 3'd5) ? 5 : int'(len);
        t = 1;
        for (int i = 0; i < eff; i++) begin
            m = code[i] ? 12 : 4;
            if (c >= t && c < t + m) return code[i] ? 6'b101001 : 6'b110001;
            t += m;
            if (i < eff - 1) begin
                if (c >= t && c < t + 4) return 6'b000001;
                t += 4;
            end
        end
        if (c >= t && c < t + 12) return 6'b000001;
        return 6'b000110;
    endfunction

    // Check cycles 1..ncyc of a letter accepted at the previous edge
    task automatic play(input logic [4:0] code, input logic [2:0] len, input string tag,
                        input int ncyc, input bit scramble, output int done_at);
        done_at = -1;
        for (int c = 1; c <= ncyc; c++) begin
            if (scramble && c == 2) begin
                r_code = 5'b11111;
                r_len  = 3'd5;
            end
            check($sformatf("%s c%0d", tag, c), 32'(w_outs), 32'(exp_outs(code, len, c)));
            if (w_done && done_at < 0) done_at = c;
            if (c < ncyc) step();
        end
    endtask

    // Present a letter and take the accept edge; returns at cycle 1
    task automatic send(input logic [4:0] code, input logic [2:0] len);
        r_code  = code;
        r_len   = len;
        r_valid = 1'b1;
        step();
        r_valid = 1'b0;
    endtask

    initial begin
        r_rst_n = 1'b0;
        r_code  = '0;
        r_len   = '0;
        r_valid = 1'b0;
        r_abort = 1'b0;
        step();
        step();
        check("reset state", 32'(w_outs), 32'(c_idle));
        r_rst_n = 1'b1;
        step();
        check("idle after release", 32'(w_outs), 32'(c_idle));

        // Letter A with full waveform check
        send(LETTER_A.code, LETTER_A.len);
        play(LETTER_A.code, LETTER_A.len, "A", 35, 1'b0, first_done);
        check("A done cycle", 32'(first_done), 32'd33);

        // E then T back to back with valid held high
        r_code  = LETTER_E.code;
        r_len   = LETTER_E.len;
        r_valid = 1'b1;
        step();
        r_code  = LETTER_T.code;
        r_len   = LETTER_T.len;
        play(LETTER_E.code, LETTER_E.len, "E", 17, 1'b0, first_done);
        check("E done cycle", 32'(first_done), 32'd17);
        step();
        play(LETTER_T.code, LETTER_T.len, "T after E", 25, 1'b0, first_done);
        r_valid = 1'b0;
        check("T done cycle", 32'(first_done + 17), 32'd42);

        // Abort in the middle of the dash of T
        send(LETTER_T.code, LETTER_T.len);
        play(LETTER_T.code, LETTER_T.len, "T pre-abort", 6, 1'b0, first_done);
        r_abort = 1'b1;
        step();
        r_abort = 1'b0;
        check("abort -> idle", 32'(w_outs), 32'(c_idle));
        step();
        check("idle after abort", 32'(w_outs), 32'(c_idle));

        // Silent letter
        send(5'b00000, 3'd0);
        play(5'b00000, 3'd0, "len0", 14, 1'b0, first_done);
        check("len0 done cycle", 32'(first_done), 32'd13);

        // Over-length letter clipped to five dashes
        send(5'b11111, 3'd7);
        play(5'b11111, 3'd7, "len7", 90, 1'b0, first_done);
        check("len7 done cycle", 32'(first_done), 32'd89);

        // Abort and valid together in DONE: abort wins, letter not taken
        r_code  = LETTER_T.code;
        r_len   = LETTER_T.len;
        r_valid = 1'b1;
        r_abort = 1'b1;
        step();
        r_valid = 1'b0;
        r_abort = 1'b0;
        check("abort+valid in DONE", 32'(w_outs), 32'(c_idle));
        step();
        check("no accept after abort+valid", 32'(w_outs), 32'(c_idle));

        // Asynchronous reset during the first SPACE of A
        send(LETTER_A.code, LETTER_A.len);
        play(LETTER_A.code, LETTER_A.len, "A pre-reset", 6, 1'b0, first_done);
        r_rst_n = 1'b0;
        #2;
        check("async reset mid-space", 32'(w_outs), 32'(c_idle));
        #2;
        r_rst_n = 1'b1;
        step();
        check("idle after async reset", 32'(w_outs), 32'(c_idle));
        send(LETTER_A.code, LETTER_A.len);
        play(LETTER_A.code, LETTER_A.len, "A post-reset", 35, 1'b0, first_done);
        check("A post-reset done cycle", 32'(first_done), 32'd33);

        // Inputs changed after accept must be ignored
        r_abort = 1'b1;
        step();
        r_abort = 1'b0;
        send(LETTER_A.code, LETTER_A.len);
        play(LETTER_A.code, LETTER_A.len, "A scrambled", 35, 1'b1, first_done);
        check("A scrambled done cycle", 32'(first_done), 32'd33);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_morse_keyer
`default_nettype wire
